// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: active-low segment
// patterns (bit0=a .. bit6=g) and the per-digit capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational reverse decoder: active-low segment pattern -> hex nibble.
// ok is low for any pattern that is not one of the sixteen glyphs (or blank,
// when blank is configured to read as zero).
module seg7_pattern_dec
    import seg7_pkg::*;
#(
    parameter int BLANK_IS_ZERO = 1
) (
    input  logic [6:0] seg_n,
    output logic       ok,
    output logic [3:0] nibble
);

    // Pattern lookup; unknown codes fall through to the invalid default.
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        ok     = 1'b1;
        nibble = 4'h0;
        case (seg_n)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: ok     = (BLANK_IS_ZERO != 0);
            default:   ok     = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus monitor: debounces each strobed digit, decodes it
// back to a nibble, assembles an NDIG-digit frame and publishes it over
// valid/ready. Frames completing while the output is still held are dropped
// and flagged in a sticky overflow bit.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYC    = 3,
    parameter int BLANK_IS_ZERO = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     dig_sel_n,
    output logic [4*NDIG-1:0]   value_o,
    output logic                value_valid,
    input  logic                value_ready,
    output logic                err_pattern,
    output logic                overflow
);

    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC + 1) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] STABLE_L = CNT_W'(STABLE_CYC);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [6:0]              seg_prev_q;
    logic [NDIG-1:0]         sel_prev_q;
    logic [NDIG-1:0]         mask_q, mask_d;
    logic [NDIG-1:0][3:0]    shadow_q, shadow_d;
    logic [4*NDIG-1:0]       value_q, value_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    ovf_q, ovf_d;

    logic [NDIG-1:0]         sel_low;
    logic                    sel_ok;
    logic [IDX_W-1:0]        sel_idx;
    logic                    changed;
    logic                    restart;
    logic                    accept;
    logic                    dec_ok;
    logic [3:0]              dec_nib;

    seg7_pattern_dec #(
        .BLANK_IS_ZERO(BLANK_IS_ZERO)
    ) u_dec (
        .seg_n  (seg_n),
        .ok     (dec_ok),
        .nibble (dec_nib)
    );

    // Strobe qualification: exactly one select low, plus its digit index.
    always_comb begin
        sel_low = ~dig_sel_n;
        sel_ok  = (sel_low != '0) && ((sel_low & (sel_low - NDIG'(1))) == '0);
        sel_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_low[i]) sel_idx = IDX_W'(i);
        end
        changed = (seg_n != seg_prev_q) || (dig_sel_n != sel_prev_q);
        cnt_inc = cnt_q + CNT_W'(1);
    end

    // Capture FSM: count identical cycles and accept a digit once per change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        restart = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: restart = sel_ok;
            SETTLE: begin
                if (changed) begin
                    if (sel_ok) restart = 1'b1;
                    else        state_d = IDLE;
                end else if (cnt_inc == STABLE_L) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLD: begin
                if (changed) begin
                    if (sel_ok) restart = 1'b1;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh valid select is its own first stable cycle.
        if (restart) begin
            cnt_d = CNT_W'(1);
            if (STABLE_CYC <= 1) begin
                accept  = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = SETTLE;
            end
        end
        if (state_d == IDLE) cnt_d = '0;
    end

    // Frame assembly, publish/drop decision and output handshake.
    always_comb begin
        mask_d   = mask_q;
        shadow_d = shadow_q;
        value_d  = value_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        ovf_d    = ovf_q;
        if (valid_q && value_ready) valid_d = 1'b0;
        if (accept) begin
            if (dec_ok) begin
                shadow_d[sel_idx] = dec_nib;
                mask_d[sel_idx]   = 1'b1;
                if (&mask_d) begin
                    if (!valid_q || value_ready) begin
                        value_d = shadow_d;
                        valid_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    mask_d = '0;
                end
            end else begin
                err_d  = 1'b1;
                mask_d = '0;
            end
        end
    end

    // Control and output registers, cleared by synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            seg_prev_q <= '1;
            sel_prev_q <= '1;
            mask_q     <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_prev_q <= seg_n;
            sel_prev_q <= dig_sel_n;
            mask_q     <= mask_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    // Frame shadow storage.
    // NOTE: no reset here; a slot is only ever read after the mask shows it was written.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign value_o     = value_q;
    assign value_valid = valid_q;
    assign err_pattern = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=4, STABLE_CYC=3, BLANK_IS_ZERO=1).
module tb_seg7_scan_decoder;

    localparam int NDIG = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [6:0]          seg_n;
    logic [NDIG-1:0]     dig_sel_n;
    logic [4*NDIG-1:0]   value_o;
    logic                value_valid;
    logic                value_ready;
    logic                err_pattern;
    logic                overflow;

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NDIG(NDIG),
        .STABLE_CYC(3),
        .BLANK_IS_ZERO(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_sel_n   (dig_sel_n),
        .value_o     (value_o),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .err_pattern (err_pattern),
        .overflow    (overflow)
    );

    // Counts cycles with err_pattern high, sampled mid-cycle.
    always @(negedge clk) if (err_pattern === 1'b1) err_seen++;

    // Strobe digit idx with pattern seg for cyc clock edges; returns 1 time unit after the last edge.
    task automatic show(input int idx, input logic [6:0] seg, input int cyc);
        logic [NDIG-1:0] one_low;
        one_low   = 4'b0001;
        seg_n     = seg;
        dig_sel_n = ~(one_low << idx);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        dig_sel_n = '1;
        seg_n     = 7'h7F;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (value_o !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h want 0000", value_o); end
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", value_valid); end
        checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_pattern); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        go_idle();
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", value_valid); end
    endtask

    task automatic test_scan_1a3f();
        int e0;
        e0 = err_seen;
        value_ready = 1'b1;
        go_idle();
        show(0, 7'h0E, 3);
        show(1, 7'h30, 3);
        show(2, 7'h08, 3);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL scan_early_valid: got %b want 0", value_valid); end
        show(3, 7'h79, 3);
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL scan_valid: got %b want 1", value_valid); end
        checks++; if (value_o !== 16'h1A3F) begin errors++; $display("FAIL scan_value: got %h want 1a3f", value_o); end
        show(3, 7'h79, 1);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL scan_valid_drop: got %b want 0", value_valid); end
        checks++; if (err_seen !== e0) begin errors++; $display("FAIL scan_err: got %0d err cycles want 0", err_seen - e0); end
    endtask

    task automatic test_glitch();
        value_ready = 1'b1;
        go_idle();
        show(0, 7'h40, 2);
        show(0, 7'h79, 3);
        show(1, 7'h30, 3);
        show(2, 7'h24, 3);
        show(3, 7'h79, 3);
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid: got %b want 1", value_valid); end
        checks++; if (value_o !== 16'h1231) begin errors++; $display("FAIL glitch_value: got %h want 1231", value_o); end
        // A two-cycle digit must not count toward the next frame.
        go_idle();
        show(0, 7'h40, 2);
        go_idle();
        show(1, 7'h79, 3);
        show(2, 7'h24, 3);
        show(3, 7'h30, 3);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL short_digit_valid: got %b want 0", value_valid); end
        show(0, 7'h12, 3);
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL short_fill_valid: got %b want 1", value_valid); end
        checks++; if (value_o !== 16'h3215) begin errors++; $display("FAIL short_fill_value: got %h want 3215", value_o); end
    endtask

    task automatic test_invalid();
        int e0;
        value_ready = 1'b1;
        go_idle();
        e0 = err_seen;
        show(0, 7'h40, 3);
        show(1, 7'h79, 3);
        show(2, 7'h7E, 2);
        checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL invalid_early_err: got %b want 0", err_pattern); end
        show(2, 7'h7E, 1);
        checks++; if (err_pattern !== 1'b1) begin errors++; $display("FAIL invalid_err: got %b want 1", err_pattern); end
        show(2, 7'h7E, 1);
        checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL invalid_err_pulse: got %b want 0", err_pattern); end
        show(3, 7'h30, 3);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL invalid_no_frame: got %b want 0", value_valid); end
        show(3, 7'h40, 3);
        show(2, 7'h03, 3);
        show(1, 7'h00, 3);
        show(0, 7'h21, 3);
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL recover_valid: got %b want 1", value_valid); end
        checks++; if (value_o !== 16'h0B8D) begin errors++; $display("FAIL recover_value: got %h want 0b8d", value_o); end
        show(0, 7'h21, 2);
        checks++; if (err_seen - e0 !== 1) begin errors++; $display("FAIL invalid_err_cycles: got %0d want 1", err_seen - e0); end
    endtask

    task automatic test_backpressure();
        value_ready = 1'b0;
        go_idle();
        show(3, 7'h79, 3);
        show(2, 7'h24, 3);
        show(1, 7'h30, 3);
        show(0, 7'h19, 3);
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", value_valid); end
        checks++; if (value_o !== 16'h1234) begin errors++; $display("FAIL bp_first_value: got %h want 1234", value_o); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_first_ovf: got %b want 0", overflow); end
        show(3, 7'h12, 3);
        show(2, 7'h02, 3);
        show(1, 7'h78, 3);
        show(0, 7'h00, 3);
        checks++; if (value_o !== 16'h1234) begin errors++; $display("FAIL bp_hold_value: got %h want 1234", value_o); end
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", value_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b want 1", overflow); end
        value_ready = 1'b1;
        show(0, 7'h00, 1);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", value_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_selects();
        value_ready = 1'b1;
        go_idle();
        seg_n     = 7'h79;
        dig_sel_n = 4'b1100;
        repeat (5) @(posedge clk);
        #1;
        dig_sel_n = 4'b1111;
        repeat (5) @(posedge clk);
        #1;
        show(2, 7'h46, 3);
        show(3, 7'h06, 3);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL sel_multi_valid: got %b want 0", value_valid); end
        show(1, 7'h21, 3);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL sel_three_valid: got %b want 0", value_valid); end
        show(0, 7'h7F, 3);
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL blank_valid: got %b want 1", value_valid); end
        checks++; if (value_o !== 16'hECD0) begin errors++; $display("FAIL blank_value: got %h want ecd0", value_o); end
    endtask

    task automatic test_reset_mid();
        value_ready = 1'b1;
        go_idle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf_before: got %b want 1", overflow); end
        show(0, 7'h40, 3);
        show(1, 7'h79, 3);
        show(2, 7'h24, 3);
        reset = 1'b1;
        show(2, 7'h24, 2);
        checks++; if (value_o !== 16'h0000) begin errors++; $display("FAIL mid_reset_value: got %h want 0000", value_o); end
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", value_valid); end
        checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL mid_reset_err: got %b want 0", err_pattern); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        go_idle();
        show(3, 7'h30, 3);
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL mid_partial_valid: got %b want 0", value_valid); end
        show(3, 7'h46, 3);
        show(2, 7'h40, 3);
        show(1, 7'h21, 3);
        show(0, 7'h06, 3);
        checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid: got %b want 1", value_valid); end
        checks++; if (value_o !== 16'hC0DE) begin errors++; $display("FAIL mid_new_value: got %h want c0de", value_o); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_new_ovf: got %b want 0", overflow); end
    endtask

    initial begin
        reset       = 1'b1;
        seg_n       = 7'h7F;
        dig_sel_n   = '1;
        value_ready = 1'b0;
        test_reset();
        test_scan_1a3f();
        test_glitch();
        test_invalid();
        test_backpressure();
        test_selects();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
